// File: rtl/rst_release_sequencer_if.sv
// Software reset req/ack handshake bundle.
// Four-phase level protocol between requester and sequencer.
interface rst_release_sequencer_if;
    logic sw_rst_req_i;
    logic sw_rst_ack_o;

    modport master (
        output sw_rst_req_i,
        input  sw_rst_ack_o
    );

    modport slave (
        input  sw_rst_req_i,
        output sw_rst_ack_o
    );
endinterface

// File: rtl/rst_release_sequencer.sv
// Staged reset release with programmable spacing.
// Software req replays the sequence; ack on completion.
module rst_release_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int MIN_ASSERT  = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    rst_release_sequencer_if.slave sw_if,
    output logic [NUM_STAGES-1:0]  stage_rstn_o,
    output logic                   seq_done_o,
    output logic                   busy_o
);

    localparam int MAXD =
        (STAGE_DELAY > MIN_ASSERT) ? STAGE_DELAY : MIN_ASSERT;
    localparam int CNT_W = $clog2(MAXD + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  pend_q, pend_d;
    logic                  req;

    assign req = sw_if.sw_rst_req_i;

    // State and every output flop, all cleared by the async reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state: hold, staged release, then idle awaiting requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        busy_d  = busy_q;
        ack_d   = ack_q;
        pend_d  = pend_q;

        if (ack_q && !req) begin
            ack_d = 1'b0;
        end

        unique case (state_q)
            HOLD: begin
                if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
                    stage_d = NUM_STAGES'(1);
                    idx_d   = IDX_W'(1);
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (idx_q == IDX_W'(NUM_STAGES)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (pend_q) begin
                        ack_d  = 1'b1;
                        pend_d = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Only a fresh request: req high with ack already low.
                if (req && !ack_q) begin
                    stage_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    pend_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign stage_rstn_o       = stage_q;
    assign seq_done_o         = done_q;
    assign busy_o             = busy_q;
    assign sw_if.sw_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Directed bench for rst_release_sequencer.
// Checks default and minimal configurations.
module tb_rst_release_sequencer;

    logic       clk_i;
    logic       rstn_i;
    logic [3:0] stage;
    logic       done;
    logic       busy;
    logic [0:0] stage2;
    logic       done2;
    logic       busy2;
    int         errs;
    int         nchk;

    rst_release_sequencer_if u_if ();
    rst_release_sequencer_if u_if2 ();

    rst_release_sequencer u_dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .sw_if        (u_if.slave),
        .stage_rstn_o (stage),
        .seq_done_o   (done),
        .busy_o       (busy)
    );

    rst_release_sequencer #(
        .NUM_STAGES  (1),
        .STAGE_DELAY (1),
        .MIN_ASSERT  (1)
    ) u_dut2 (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .sw_if        (u_if2.slave),
        .stage_rstn_o (stage2),
        .seq_done_o   (done2),
        .busy_o       (busy2)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected stage vector r edges after sequence start.
    function automatic logic [3:0] exp_stage(input int r);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (r >= 8 + 16 * k) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic chk_rst_vals(input string tag);
        check({tag, "_stg"}, 32'(stage), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h1);
        check({tag, "_ack"}, 32'(u_if.sw_rst_ack_o), 32'h0);
    endtask

    task automatic chk_main(input string tag,
                            input int r,
                            input logic ack_exp);
        check({tag, "_stg"}, 32'(stage), 32'(exp_stage(r)));
        check({tag, "_done"}, 32'(done), 32'(r >= 57));
        check({tag, "_busy"}, 32'(busy), 32'(r < 57));
        check({tag, "_ack"}, 32'(u_if.sw_rst_ack_o), 32'(ack_exp));
    endtask

    initial begin
        errs   = 0;
        nchk   = 0;
        rstn_i = 1'b0;
        u_if.sw_rst_req_i  = 1'b0;
        u_if2.sw_rst_req_i = 1'b0;

        // Reset values while rstn_i is low, clock running.
        tick();
        tick();
        chk_rst_vals("rst");
        check("rst_stg2", 32'(stage2), 32'h0);
        check("rst_busy2", 32'(busy2), 32'h1);

        // Plain power-up.
        rstn_i = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick();
            chk_main("pwr", e, 1'b0);
            check("pwr_stg2", 32'(stage2), 32'(e >= 1));
            check("pwr_done2", 32'(done2), 32'(e >= 2));
        end

        // Software reset replay from RUN.
        u_if.sw_rst_req_i = 1'b1;
        for (int r = 0; r <= 59; r++) begin
            tick();
            chk_main("sw", r, r >= 57);
        end
        // Holding req must not retrigger.
        for (int i = 0; i < 100; i++) begin
            tick();
            check("hold_stg", 32'(stage), 32'hf);
            check("hold_ack", 32'(u_if.sw_rst_ack_o), 32'h1);
        end
        u_if.sw_rst_req_i = 1'b0;
        tick();
        check("drop_ack", 32'(u_if.sw_rst_ack_o), 32'h0);
        check("drop_stg", 32'(stage), 32'hf);
        check("drop_done", 32'(done), 32'h1);

        // Async reset mid-handshake with ack high.
        u_if.sw_rst_req_i = 1'b1;
        tick();
        tick();
        check("hs_pre", 32'(stage), 32'h0);
        repeat (60) tick();
        check("hs_ack", 32'(u_if.sw_rst_ack_o), 32'h1);
        rstn_i = 1'b0;
        #1;
        chk_rst_vals("hsrst");
        u_if.sw_rst_req_i = 1'b0;
        tick();

        // Async reset at edge 45, mid-release.
        rstn_i = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            chk_main("p45", e, 1'b0);
        end
        rstn_i = 1'b0;
        #1;
        chk_rst_vals("mid");
        tick();
        tick();
        tick();
        chk_rst_vals("mid_hold");
        rstn_i = 1'b1;
        for (int e = 1; e <= 58; e++) begin
            tick();
            chk_main("rpw", e, 1'b0);
        end

        // Request raised during power-up, taken at first RUN edge.
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        for (int e = 1; e <= 116; e++) begin
            if (e == 30) u_if.sw_rst_req_i = 1'b1;
            tick();
            if (e < 58) chk_main("e30", e, 1'b0);
            else        chk_main("e30sw", e - 58, (e - 58) >= 57);
        end
        u_if.sw_rst_req_i = 1'b0;
        tick();
        check("e30_drop", 32'(u_if.sw_rst_ack_o), 32'h0);

        // Minimal config software handshake.
        u_if2.sw_rst_req_i = 1'b1;
        tick();
        check("m_e0_stg", 32'(stage2), 32'h0);
        check("m_e0_done", 32'(done2), 32'h0);
        tick();
        check("m_e1_stg", 32'(stage2), 32'h1);
        check("m_e1_ack", 32'(u_if2.sw_rst_ack_o), 32'h0);
        tick();
        check("m_e2_ack", 32'(u_if2.sw_rst_ack_o), 32'h1);
        check("m_e2_done", 32'(done2), 32'h1);
        check("m_e2_busy", 32'(busy2), 32'h0);
        u_if2.sw_rst_req_i = 1'b0;
        tick();
        check("m_drop", 32'(u_if2.sw_rst_ack_o), 32'h0);
        check("m_stg", 32'(stage2), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
